// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven initiator for an external WIDTH-bit up/down counter.
//
// Accepts LOAD / RUN_TO / PINGPONG / STOP commands over a valid/ready handshake. It drives the
// counter's load/en/up_down/data_in pins cycle by cycle and watches the fed-back q to decide
// when to stop or reverse.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready command handshake; ready in IDLE, or for STOP at any time
//   cmd_op          00 LOAD, 01 RUN_TO, 10 PINGPONG, 11 STOP
//   cmd_data        load value / target / bound
//   q               current counter value (feedback)
//   load, data_in   registered load strobe and load value to the counter
//   en, up_down     combinational count enable / direction to the counter
//   busy            high whenever the sequencer is not idle
//   done            one-cycle completion pulse (LOAD, RUN_TO, PINGPONG with bound 0)
//   laps            PINGPONG round trips completed, wraps modulo 2^WIDTH
module counter_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q,
  output logic             load,
  output logic             en,
  output logic             up_down,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] laps
);

  localparam logic [1:0] OpLoad     = 2'b00;
  localparam logic [1:0] OpRunTo    = 2'b01;
  localparam logic [1:0] OpPingPong = 2'b10;
  localparam logic [1:0] OpStop     = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoading,
    StRun,
    StPingUp,
    StPingDn
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  // Shared register: RUN_TO target or PINGPONG bound, never both at once.
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] laps_q, laps_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             accept;

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    tgt_d     = tgt_q;
    laps_d    = laps_q;
    done_d    = 1'b0;
    en        = 1'b0;
    up_down   = 1'b0;

    cmd_ready = (state_q == StIdle) || (cmd_op == OpStop);
    accept    = cmd_valid && cmd_ready;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op)
            OpLoad: begin
              data_in_d = cmd_data;
              state_d   = StLoading;
            end
            OpRunTo: begin
              tgt_d   = cmd_data;
              state_d = StRun;
            end
            OpPingPong: begin
              tgt_d  = cmd_data;
              laps_d = '0;
              if (cmd_data == '0) begin
                // Degenerate bound: finish immediately without counting.
                done_d = 1'b1;
              end else begin
                state_d = StPingUp;
              end
            end
            OpStop: begin
              state_d = StIdle;
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StLoading: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end

      StRun: begin
        if (q == tgt_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          en      = 1'b1;
          up_down = (q < tgt_q);
        end
      end

      StPingUp: begin
        en = 1'b1;
        if (q < tgt_q) begin
          up_down = 1'b1;
        end else begin
          // At or above the bound (also covers entry with q > bound): turn around now.
          up_down = 1'b0;
          state_d = StPingDn;
        end
      end

      StPingDn: begin
        en = 1'b1;
        if (q != '0) begin
          up_down = 1'b0;
        end else begin
          up_down = 1'b1;
          state_d = StPingUp;
          laps_d  = laps_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // STOP while busy: this cycle's pin drive stands, but the next state is IDLE and no
    // completion is reported.
    if (accept && (cmd_op == OpStop) && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end

    load_d = (state_d == StLoading);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_in_q <= '0;
      tgt_q     <= '0;
      laps_q    <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_in_q <= data_in_d;
      tgt_q     <= tgt_d;
      laps_q    <= laps_d;
      load_q    <= load_d;
      done_q    <= done_d;
    end
  end

  assign load    = load_q;
  assign data_in = data_in_q;
  assign done    = done_q;
  assign laps    = laps_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven initiator for the 8-bit programmable up/down counter, which has load, en, up_down, data_in and q. It accepts commands over a valid/ready interface: load a value, count to a target, or ping-pong between 0 and a bound. From those commands it drives the counter's control inputs cycle by cycle and watches q to decide when to stop or reverse. It sits between the pin-level command decode and the counter instance in the top level.

Parameters:
WIDTH, 8, counter and data width; must match the counter instance.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
cmd_op  input  2  command: 00 LOAD, 01 RUN_TO, 10 PINGPONG, 11 STOP.
cmd_data  input  WIDTH  load value, target or bound.
q  input  WIDTH  current counter value, fed back from the counter.
load  output  1  to counter: synchronous load strobe.
en  output  1  to counter: count enable.
up_down  output  1  to counter: 1 = up, 0 = down.
data_in  output  WIDTH  to counter: load value.
busy  output  1  high when state != IDLE.
done  output  1  one-cycle completion pulse.
laps  output  WIDTH  PINGPONG round trips completed; wraps modulo 2^WIDTH.

Behaviour:
- Reset (async, rst_n=0): state IDLE; load=0, en=0, up_down=0, data_in=0, done=0, laps=0; internal target/bound cleared to 0.
- Reset mid-operation: all outputs go to their reset values immediately; the command in progress is lost.
- Counter contract: counter samples load/en/up_down/data_in at the rising edge; q shows the new value the next cycle; load has priority over en.
- en and up_down are combinational decodes of the registered state and q. load, data_in, done and laps are registered.
- States:
  - IDLE: en=0, load=0, up_down=0.
  - LOADING: load=1, en=0, data_in=latched value. Lasts exactly 1 cycle, then IDLE.
  - RUN: if q==target, en=0 and next state is IDLE. Otherwise en=1 and up_down=(q<target).
  - PING_UP: en=1. If q<bound, up_down=1. If q>=bound, up_down=0 and next state is PING_DN.
  - PING_DN: en=1. If q>0, up_down=0. If q==0, up_down=1, next state is PING_UP, and laps increments.
- cmd_ready = (state==IDLE) || (cmd_op==STOP). While busy, only STOP is accepted.
- Acceptance in IDLE:
  - LOAD: latch cmd_data into data_in; go to LOADING.
  - RUN_TO: latch target; go to RUN.
  - PINGPONG: latch bound; clear laps; go to PING_UP. If bound==0, go to IDLE instead with done pulsed and no counting.
  - STOP: no effect, no done.
- STOP while busy: the acceptance cycle still drives outputs per the current state. From the next cycle the state is IDLE and en=0. done is not pulsed.
- done is asserted for exactly one cycle, in the first IDLE cycle after LOADING completes or after RUN reaches target. It is never asserted for STOP.
- RUN_TO with target==q at acceptance: one RUN cycle with en=0, then IDLE with done pulsed.
- RUN never wraps, because direction is always toward the target.
- PINGPONG with q>bound at entry: PING_UP reverses immediately and counts down. Sequence from q=0 with bound=B: 0,1,…,B,B-1,…,0,1,…
- Arithmetic: comparisons are unsigned, full WIDTH. laps wraps 255→0.
- Back-to-back: a new command can be accepted in the same cycle done is high (state is IDLE).

Test Plan:
- Reset with rst_n low mid-PINGPONG -> all outputs 0 in the same cycle; busy=0; laps=0.
- LOAD 0x5A -> next cycle load=1 with data_in=0x5A for exactly 1 cycle; done the following cycle; q=0x5A.
- With q=0x10: RUN_TO 0x14 -> en high for 4 cycles with up_down=1; q stops at 0x14; single done pulse. Then RUN_TO 0x0E -> 6 down steps, stops at 0x0E.
- PINGPONG bound=3 from q=0 -> q sequence 0,1,2,3,2,1,0,1… with no stall cycles; laps increments each time q returns to 0.
- During RUN, STOP with cmd_valid held -> cmd_ready=1; en=0 from the next cycle; q frozen; done never asserted. During RUN, LOAD -> cmd_ready=0 and the command stays pending.
- Edge cases: RUN_TO target equal to current q -> done after 2 cycles with zero count steps. PINGPONG bound=0 -> immediate done, en never high. 256 round trips -> laps wraps to 0.
